seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised multiplexed seven-segment display driver, successor to the fixed 4-digit scanner. Drives `NUM_DIGITS` common-anode/cathode digits from one packed byte-per-digit input with a programmable scan rate, per-frame data snapshot, optional hex decode and PWM brightness control. Sits between the register/status logic that produces display values and the board pins (segments A–G, DP, digit selects).

## Interface

- `NUM_DIGITS`, 4: digits scanned; ≥2.
- `DIV_WIDTH`, 10: slot length per digit = 2^DIV_WIDTH clocks; must be > `PWM_BITS`.
- `PWM_BITS`, 4: brightness resolution.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg`.
- `DIG_ACTIVE_LOW`, 1: 1 means the selected digit is driven 0, others 1.

- `clock`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  scan enable.
- `hex_mode`  in  1  1: low nibble decoded to glyph, bit 7 = DP; 0: byte is raw segments.
- `brightness`  in  `PWM_BITS`  on-time within each slot.
- `digit_data`  in  `8*NUM_DIGITS`  byte i = digit i; bit0=A … bit6=G, bit7=DP.
- `seg`  out  8  segment drive (polarity per `SEG_ACTIVE_LOW`).
- `dig`  out  `NUM_DIGITS`  digit select (polarity per `DIG_ACTIVE_LOW`).
- `frame_start`  out  1  one-cycle pulse when digit 0 slot begins.

## Operation

- Prescaler `pre` (`DIV_WIDTH` bits) increments every clock while `enable`; wrap to 0 advances digit index `idx` (0…NUM_DIGITS-1, wraps to 0).
- Snapshot: at every cycle with `enable`=1, `pre`=0, `idx`=0, `digit_data` is captured into a shadow register; all slots of that frame display the shadow. Mid-frame input changes are invisible until the next frame.
- PWM phase = `pre[DIV_WIDTH-1 -: PWM_BITS]`. Digit `idx` is lit while phase < `brightness`; otherwise all digits inactive and `seg` inactive. `brightness`=0 → dark; max → (2^PWM_BITS−1)/2^PWM_BITS duty.
- Glyph: `hex_mode`=1 → standard hex font 0–F on A–G, DP = bit 7; `hex_mode`=0 → byte passed through. `hex_mode`/`brightness` are sampled live (no snapshot).
- Exactly one digit active at any time or none; never two.
- `enable`=0: `pre` and `idx` synchronously cleared, outputs inactive, no `frame_start`. Re-enable starts at digit 0 with a fresh snapshot.

## Timing

- Reset (async assert, sync release by board): `pre`=0, `idx`=0, shadow=0, `seg` inactive, `dig` all inactive, `frame_start`=0.
- Outputs registered: state in cycle k appears on `seg`/`dig` in cycle k+1. Snapshot at cycle k appears on pins at k+1.
- `frame_start` asserted in the same cycle the digit-0 output first reflects the new slot (cycle after snapshot), regardless of brightness.
- Frame period = NUM_DIGITS·2^DIV_WIDTH clocks; no dead cycles between slots beyond PWM off-time.
- Reset mid-frame: outputs inactive immediately (asynchronous); restart as above.
- `enable` drop mid-slot: outputs inactive from next cycle.

## Structure

- Package `seven_seg_pkg`: segment bit positions (A…G, DP), 16-entry hex glyph constant, polarity helper.
- Sub-module `hex_to_seg` (combinational 4→7 lookup from package constant); scanner instantiates one copy on the selected shadow byte.

## Test plan

Bench uses NUM_DIGITS=4, DIV_WIDTH=6, PWM_BITS=2, DIG_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0.
- Reset, then hold: `seg`=8'h00, `dig`=4'b1111 during and after reset with `enable`=0.
- `enable`=1, `brightness`=3, `hex_mode`=0, `digit_data`=32'h4F5B0639 → dig cycles 1110,1101,1011,0111 with seg 39,06,5B,4F; each slot 64 clocks, lit 48; `frame_start` every 256 clocks.
- `hex_mode`=1, data 32'h8F0A0301 → digit0 seg=06, digit1 4F, digit2 77, digit3 F1 (8'h71|DP).
- Change `digit_data` mid-frame (cycle 100) → current frame unchanged; new values from next `frame_start`.
- `brightness`=0 → dig stays 1111 but `frame_start` still pulses; `brightness`=1 → 16 lit clocks per slot.
- Deassert `enable` at cycle 150, reassert at 200; assert `rst_n`=0 mid-slot → outputs inactive next cycle / immediately; restart shows digit 0 with snapshot taken at re-enable.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_pkg: segment bit positions, hex glyph font and pin polarity helper
package seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Entry n is the A..G pattern for hex digit n, A in bit 0
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] seg_drive(input logic [7:0] v, input bit active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: display values/controls in, segment and digit pins out
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int PWM_BITS   = 4
);

    logic                    enable;
    logic                    hex_mode;
    logic [PWM_BITS-1:0]     brightness;
    logic [8*NUM_DIGITS-1:0] digit_data;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   dig;
    logic                    frame_start;

    modport master (
        output enable, hex_mode, brightness, digit_data,
        input  seg, dig, frame_start
    );

    modport slave (
        input  enable, hex_mode, brightness, digit_data,
        output seg, dig, frame_start
    );

endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// hex_to_seg: combinational nibble to A..G glyph lookup
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment driver with per-frame snapshot,
// optional hex decode and PWM brightness; all pins registered.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV_WIDTH      = 10,
    parameter int PWM_BITS       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic              clock,
    input  logic              rst_n,
    seven_seg_scanner_if.slave bus
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [7:0]            SEG_OFF = seg_drive(8'h00, SEG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

    logic [DIV_WIDTH-1:0]    pre;
    logic [IW-1:0]           idx;
    logic [8*NUM_DIGITS-1:0] shadow;
    logic [PWM_BITS-1:0]     phase;
    logic                    snap;
    logic                    lit;
    logic [7:0]              raw;
    logic [6:0]              hex_glyph;
    logic [7:0]              glyph;
    logic [NUM_DIGITS-1:0]   one_hot;
    logic [7:0]              seg_d;
    logic [NUM_DIGITS-1:0]   dig_d;
    logic [7:0]              seg_q;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic                    frame_q;

    hex_to_seg u_hex (
        .nibble (raw[3:0]),
        .glyph  (hex_glyph)
    );

    // The snapshot cycle shows the incoming byte directly so it reaches the
    // pins in the same cycle the shadow register takes it.
    always_comb begin
        snap    = bus.enable && pre == '0 && idx == '0;
        phase   = pre[DIV_WIDTH-1 -: PWM_BITS];
        lit     = bus.enable && phase < bus.brightness;
        raw     = snap ? bus.digit_data[7:0] : shadow[idx*8 +: 8];
        glyph   = bus.hex_mode ? {raw[SEG_DP], hex_glyph} : raw;
        one_hot = lit ? NUM_DIGITS'(1) << idx : '0;
        seg_d   = seg_drive(lit ? glyph : 8'h00, SEG_ACTIVE_LOW);
        dig_d   = DIG_ACTIVE_LOW ? ~one_hot : one_hot;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= '0;
            shadow  <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            frame_q <= 1'b0;
        end else begin
            if (!bus.enable) begin
                pre <= '0;
                idx <= '0;
            end else begin
                pre <= pre + 1'b1;
                if (pre == '1)
                    idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            if (snap)
                shadow <= bus.digit_data;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= snap;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dig         = dig_q;
    assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan order, snapshot, hex decode,
// brightness, enable drop and asynchronous reset on a 4-digit, 64-clock-slot build.
module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int DW = 6;
    localparam int PB = 2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          slot;
    int          br;
    bit          lit;
    logic [3:0]  exp_dig;
    logic [7:0]  exp_seg;
    logic [31:0] data;

    seven_seg_scanner_if #(.NUM_DIGITS(N), .PWM_BITS(PB)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS     (N),
        .DIV_WIDTH      (DW),
        .PWM_BITS       (PB),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        bus.enable     = 1'b0;
        bus.hex_mode   = 1'b0;
        bus.brightness = 2'd0;
        bus.digit_data = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.seg !== 8'h00 || bus.dig !== 4'hF || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_async seg=%h dig=%b fs=%b want 00 1111 0", bus.seg, bus.dig, bus.frame_start);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.seg !== 8'h00 || bus.dig !== 4'hF || bus.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold i=%0d seg=%h dig=%b fs=%b want 00 1111 0", i, bus.seg, bus.dig, bus.frame_start);
            end
        end
    endtask

    task automatic test_raw();
        data = 32'h4F5B0639;
        br = 3;
        bus.digit_data = data;
        bus.hex_mode   = 1'b0;
        bus.brightness = 2'd3;
        bus.enable     = 1'b1;
        for (int i = 0; i < 257; i++) begin
            step();
            slot = (i % 256) / 64;
            lit = ((i % 64) / 16) < br;
            exp_dig = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? data[slot*8 +: 8] : 8'h00;
            checks++;
            if (bus.dig !== exp_dig || bus.seg !== exp_seg || bus.frame_start !== (i % 256 == 0)) begin
                errors++;
                $display("FAIL raw_scan i=%0d dig=%b/%b seg=%h/%h fs=%b", i, bus.dig, exp_dig, bus.seg, exp_seg, bus.frame_start);
            end
        end
        bus.enable = 1'b0;
        step();
        checks++;
        if (bus.seg !== 8'h00 || bus.dig !== 4'hF || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL raw_disable seg=%h dig=%b fs=%b want 00 1111 0", bus.seg, bus.dig, bus.frame_start);
        end
        idle();
    endtask

    task automatic test_hex();
        data = 32'hF1774F06;
        br = 3;
        bus.digit_data = 32'h8F0A0301;
        bus.hex_mode   = 1'b1;
        bus.brightness = 2'd3;
        bus.enable     = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            slot = i / 64;
            lit = ((i % 64) / 16) < br;
            exp_dig = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? data[slot*8 +: 8] : 8'h00;
            checks++;
            if (bus.dig !== exp_dig || bus.seg !== exp_seg || bus.frame_start !== (i == 0)) begin
                errors++;
                $display("FAIL hex_scan i=%0d dig=%b/%b seg=%h/%h fs=%b", i, bus.dig, exp_dig, bus.seg, exp_seg, bus.frame_start);
            end
        end
        bus.hex_mode = 1'b0;
        idle();
    endtask

    task automatic test_midframe();
        br = 3;
        bus.digit_data = 32'h4F5B0639;
        bus.brightness = 2'd3;
        bus.enable     = 1'b1;
        for (int i = 0; i < 512; i++) begin
            step();
            data = (i < 256) ? 32'h4F5B0639 : 32'h076D663F;
            slot = (i % 256) / 64;
            lit = ((i % 64) / 16) < br;
            exp_dig = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? data[slot*8 +: 8] : 8'h00;
            checks++;
            if (bus.dig !== exp_dig || bus.seg !== exp_seg || bus.frame_start !== (i % 256 == 0)) begin
                errors++;
                $display("FAIL midframe i=%0d dig=%b/%b seg=%h/%h fs=%b", i, bus.dig, exp_dig, bus.seg, exp_seg, bus.frame_start);
            end
            if (i == 99)
                bus.digit_data = 32'h076D663F;
        end
        idle();
    endtask

    task automatic test_brightness();
        data = 32'h7F06395B;
        bus.digit_data = data;
        bus.brightness = 2'd0;
        bus.enable     = 1'b1;
        for (int i = 0; i < 512; i++) begin
            step();
            br = (i < 256) ? 0 : 1;
            slot = (i % 256) / 64;
            lit = ((i % 64) / 16) < br;
            exp_dig = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? data[slot*8 +: 8] : 8'h00;
            checks++;
            if (bus.dig !== exp_dig || bus.seg !== exp_seg || bus.frame_start !== (i % 256 == 0)) begin
                errors++;
                $display("FAIL brightness%0d i=%0d dig=%b/%b seg=%h/%h fs=%b", br, i, bus.dig, exp_dig, bus.seg, exp_seg, bus.frame_start);
            end
            if (i == 255)
                bus.brightness = 2'd1;
        end
        idle();
    endtask

    task automatic test_enable_drop();
        br = 3;
        data = 32'h4F5B0639;
        bus.digit_data = data;
        bus.brightness = 2'd3;
        bus.enable     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            slot = i / 64;
            lit = i < 150 && ((i % 64) / 16) < br;
            exp_dig = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? data[slot*8 +: 8] : 8'h00;
            checks++;
            if (bus.dig !== exp_dig || bus.seg !== exp_seg || bus.frame_start !== (i == 0)) begin
                errors++;
                $display("FAIL enable_drop i=%0d dig=%b/%b seg=%h/%h fs=%b", i, bus.dig, exp_dig, bus.seg, exp_seg, bus.frame_start);
            end
            if (i == 149)
                bus.enable = 1'b0;
        end
        data = 32'h5E7C7739;
        bus.digit_data = data;
        bus.enable = 1'b1;
        for (int i = 0; i < 128; i++) begin
            step();
            slot = i / 64;
            lit = ((i % 64) / 16) < br;
            exp_dig = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? data[slot*8 +: 8] : 8'h00;
            checks++;
            if (bus.dig !== exp_dig || bus.seg !== exp_seg || bus.frame_start !== (i == 0)) begin
                errors++;
                $display("FAIL reenable i=%0d dig=%b/%b seg=%h/%h fs=%b", i, bus.dig, exp_dig, bus.seg, exp_seg, bus.frame_start);
            end
        end
    endtask

    task automatic test_reset_mid();
        br = 3;
        for (int i = 0; i < 20; i++)
            step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.seg !== 8'h00 || bus.dig !== 4'hF || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid seg=%h dig=%b fs=%b want 00 1111 0", bus.seg, bus.dig, bus.frame_start);
        end
        data = 32'h6D66073F;
        bus.digit_data = data;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) begin
            step();
            slot = i / 64;
            lit = ((i % 64) / 16) < br;
            exp_dig = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg = lit ? data[slot*8 +: 8] : 8'h00;
            checks++;
            if (bus.dig !== exp_dig || bus.seg !== exp_seg || bus.frame_start !== (i == 0)) begin
                errors++;
                $display("FAIL reset_restart i=%0d dig=%b/%b seg=%h/%h fs=%b", i, bus.dig, exp_dig, bus.seg, exp_seg, bus.frame_start);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_hex();
        test_midframe();
        test_brightness();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
